// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator family.
package led_pkg;

   localparam logic [1:0] MODE_ROT_L = 2'd0;
   localparam logic [1:0] MODE_ROT_R = 2'd1;
   localparam logic [1:0] MODE_PING  = 2'd2;
   localparam logic [1:0] MODE_BAR   = 2'd3;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage : led_pkg

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: emits one tick every TICK_CYCLES enabled clocks.
module tick_prescaler #(
   parameter int unsigned TICK_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // tick is combinational so the consumer can act on the edge that samples it
   assign tick = en && (cnt_q == LAST);

   // Counter holds while paused so resuming loses no phase
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         if (cnt_q == LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule : tick_prescaler

// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator: rotate, ping-pong and bar-fill modes
// with a base-tick prescaler, power-of-two speed divider, pause and restart.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned LED_W       = 12,
   parameter int unsigned TICK_CYCLES = 5_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [LED_W-1:0] dout,
   output logic             step_pulse
);

   localparam int unsigned SPD_W = 3;

   logic [1:0]       mode_q;
   logic             dir_q;
   logic             dir_d;
   logic [SPD_W-1:0] spd_cnt_q;
   logic [SPD_W-1:0] spd_cnt_d;
   logic [SPD_W-1:0] spd_lim;
   logic [LED_W-1:0] dout_d;
   logic             step_pulse_d;
   logic             tick;
   logic             trigger;
   logic             step;

   // Start pattern for each mode
   function automatic logic [LED_W-1:0] start_val(input logic [1:0] m);
      if (m == MODE_ROT_R) begin
         return LED_W'(1) << (LED_W - 1);
      end
      return LED_W'(1);
   endfunction

   assign trigger = restart || (mode != mode_q);
   assign spd_lim = SPD_W'((4'd1 << speed) - 4'd1);
   assign step    = tick && (spd_cnt_q == spd_lim);

   tick_prescaler #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (trigger),
      .tick (tick)
   );

   // Next-state: restart beats step beats hold; a step coinciding with restart is dropped
   always_comb begin
      dout_d       = dout;
      dir_d        = dir_q;
      spd_cnt_d    = spd_cnt_q;
      step_pulse_d = 1'b0;

      if (trigger) begin
         dout_d    = start_val(mode);
         dir_d     = DIR_LEFT;
         spd_cnt_d = '0;
      end else if (tick) begin
         if (step) begin
            spd_cnt_d    = '0;
            step_pulse_d = 1'b1;
            if (dout == '0) begin
               dout_d = start_val(mode_q);
            end else begin
               case (mode_q)
                  MODE_ROT_L: dout_d = {dout[LED_W-2:0], dout[LED_W-1]};
                  MODE_ROT_R: dout_d = {dout[0], dout[LED_W-1:1]};
                  MODE_PING: begin
                     if (dir_q == DIR_LEFT) begin
                        if (dout[LED_W-1]) begin
                           dir_d  = DIR_RIGHT;
                           dout_d = LED_W'(1) << (LED_W - 2);
                        end else begin
                           dout_d = dout << 1;
                        end
                     end else begin
                        if (dout[0]) begin
                           dir_d  = DIR_LEFT;
                           dout_d = LED_W'(2);
                        end else begin
                           dout_d = dout >> 1;
                        end
                     end
                  end
                  MODE_BAR: begin
                     if (&dout) begin
                        dout_d = LED_W'(1);
                     end else begin
                        dout_d = {dout[LED_W-2:0], 1'b1};
                     end
                  end
                  default: dout_d = start_val(mode_q);
               endcase
            end
         end else if (spd_cnt_q > spd_lim) begin
            // speed was lowered mid-count: realign without stepping
            spd_cnt_d = '0;
         end else begin
            spd_cnt_d = spd_cnt_q + SPD_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= LED_W'(1);
         dir_q      <= DIR_LEFT;
         spd_cnt_q  <= '0;
         step_pulse <= 1'b0;
         mode_q     <= MODE_ROT_L;
      end else begin
         dout       <= dout_d;
         dir_q      <= dir_d;
         spd_cnt_q  <= spd_cnt_d;
         step_pulse <= step_pulse_d;
         mode_q     <= mode;
      end
   end

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// Randomised scoreboard bench for led_pattern_gen (LED_W=4, TICK_CYCLES=3).
module tb_led_pattern_gen;

   localparam int W  = 4;
   localparam int TC = 3;
   localparam int N_CYCLES = 4000;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         restart;
   logic [1:0]   mode;
   logic [1:0]   speed;
   logic [W-1:0] dout;
   logic         step_pulse;

   int tests = 0;
   int fails = 0;

   // reference model state: enabled-cycle phase, ticks since last step,
   // step index since last (re)start, active mode
   int m_pre, m_tk, m_k, m_mq;
   logic [W-1:0] exp_dout = W'(1);
   logic         exp_step = 1'b0;
   logic [W-1:0] sb_q[$];
   bit           mon_on = 1'b0;

   led_pattern_gen #(.LED_W(W), .TICK_CYCLES(TC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .restart    (restart),
      .mode       (mode),
      .speed      (speed),
      .dout       (dout),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   // Pattern shown k steps after a (re)start in mode m
   function automatic logic [W-1:0] pattern(input int m, input int k);
      int p;
      case (m)
         0: return W'(1) << (k % W);
         1: return W'(1) << (W - 1 - (k % W));
         2: begin
            p = k % (2 * W - 2);
            if (p >= W) p = 2 * W - 2 - p;
            return W'(1) << p;
         end
         default: return W'((1 << ((k % W) + 1)) - 1);
      endcase
   endfunction

   function automatic bit will_step();
      return !rst && (int'(mode) == m_mq) && en && (m_pre == TC - 1) &&
             (m_tk == (1 << int'(speed)) - 1);
   endfunction

   // Advance the model by one clock edge using the inputs just driven
   task automatic model_update();
      int lim;
      bit tickv;
      exp_step = 1'b0;
      if (rst) begin
         m_pre = 0; m_tk = 0; m_k = 0; m_mq = 0;
         exp_dout = W'(1);
      end else if (restart || int'(mode) != m_mq) begin
         m_pre = 0; m_tk = 0; m_k = 0; m_mq = int'(mode);
         exp_dout = pattern(m_mq, 0);
      end else if (en) begin
         tickv = (m_pre == TC - 1);
         m_pre = (m_pre + 1) % TC;
         if (tickv) begin
            lim = 1 << int'(speed);
            if (m_tk == lim - 1) begin
               m_tk = 0;
               m_k++;
               exp_step = 1'b1;
               exp_dout = pattern(m_mq, m_k);
               sb_q.push_back(exp_dout);
            end else if (m_tk >= lim) begin
               m_tk = 0;
            end else begin
               m_tk++;
            end
         end
      end
   endtask

   // Monitor: step_pulse timing, popped step values, and the dout level every cycle
   always @(posedge clk) begin
      logic [W-1:0] e;
      #1;
      if (mon_on) begin
         tests++;
         if (step_pulse !== exp_step) begin
            fails++;
            $display("FAIL step_pulse t=%0t got %b want %b", $time, step_pulse, exp_step);
         end
         if (step_pulse === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_step t=%0t dout %b, no step expected", $time, dout);
            end else begin
               e = sb_q.pop_front();
               if (dout !== e) begin
                  fails++;
                  $display("FAIL step_value t=%0t got %b want %b", $time, dout, e);
               end
            end
         end else if (exp_step && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
         end
         tests++;
         if (dout !== exp_dout) begin
            fails++;
            $display("FAIL dout_level t=%0t got %b want %b", $time, dout, exp_dout);
         end
      end
   end

   // Driver: directed phases from the test plan, then randomised traffic
   initial begin
      rst = 1'b1; en = 1'b0; restart = 1'b0; mode = 2'd0; speed = 2'd0;
      m_pre = 0; m_tk = 0; m_k = 0; m_mq = 0;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         restart = 1'b0;
         if (cyc < 3) begin
            rst = 1'b1; en = 1'b1; mode = 2'd0; speed = 2'd0;
         end else if (cyc < 40) begin
            rst = 1'b0;
            if (cyc == 30) restart = will_step();
         end else if (cyc < 80) begin
            mode = 2'd2;
            rst = (cyc == 66);
         end else if (cyc < 110) begin
            rst = 1'b0; mode = 2'd3;
         end else if (cyc < 180) begin
            mode = 2'd1; speed = 2'd2;
            en = !(cyc >= 130 && cyc < 135);
         end else if (cyc < 200) begin
            en = 1'b1; mode = 2'd0; speed = 2'd0;
            if (cyc == 190) mode = 2'd1;
         end else begin
            rst = ($urandom % 200) == 0;
            en  = ($urandom % 8) != 0;
            if (($urandom % 60) == 0) mode = 2'($urandom_range(0, 3));
            if (($urandom % 50) == 0) speed = 2'($urandom_range(0, 3));
            restart = ($urandom % 40) == 0;
            if (!restart && will_step() && ($urandom % 4) == 0) restart = 1'b1;
         end
         model_update();
         mon_on = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0; en = 1'b0; restart = 1'b0;
      model_update();
      repeat (2) @(negedge clk);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_led_pattern_gen
